// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: EX-stage sequencer for MULT/MULTU/DIV/DIVU writing {HI,LO}.
// Ports: req/op/operands in, divider handshake out/in, stall/busy, hilo strobe+data.
module muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic [7:0]  alucontrol_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_a_o,
    output logic [31:0] div_b_o,
    output logic        stall_o,
    output logic        busy_o,
    output logic        hilo_we_o,
    output logic [63:0] hilo_o
);

    localparam logic [7:0] OP_MULT  = 8'b0001_1000;
    localparam logic [7:0] OP_MULTU = 8'b0001_1001;
    localparam logic [7:0] OP_DIV   = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic          sign_q, sign_d;
    logic [63:0]   res_q, res_d;

    logic        is_mul;
    logic        is_div;
    logic        is_signed_op;
    logic        take;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] prod_u;
    logic        neg;
    logic [63:0] product;

    assign is_mul = (alucontrol_i == OP_MULT) || (alucontrol_i == OP_MULTU);
    assign is_div = (alucontrol_i == OP_DIV) || (alucontrol_i == OP_DIVU);
    assign is_signed_op = (alucontrol_i == OP_MULT) ||
                          (alucontrol_i == OP_DIV);
    assign take = req_valid_i && (is_mul || is_div) && !flush_i;

    // Signed multiply works on magnitudes; the sign is restored on the
    // full 64-bit product so the most negative operand is handled.
    assign mag_a = (sign_q && a_q[31]) ? (~a_q + 32'd1) : a_q;
    assign mag_b = (sign_q && b_q[31]) ? (~b_q + 32'd1) : b_q;
    assign prod_u = {32'd0, mag_a} * {32'd0, mag_b};
    assign neg = sign_q && (a_q[31] ^ b_q[31]);
    assign product = neg ? (~prod_u + 64'd1) : prod_u;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        sign_d      = sign_q;
        res_d       = res_q;
        stall_o     = 1'b0;
        hilo_we_o   = 1'b0;
        div_start_o = 1'b0;
        div_annul_o = 1'b0;

        if (rst) begin
            // Outputs stay quiet while reset is applied.
            state_d = S_IDLE;
        end else if (flush_i) begin
            // Flush wins over everything, including a pending write.
            state_d     = S_IDLE;
            cnt_d       = '0;
            div_annul_o = (state_q == S_DIV);
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (take) begin
                        stall_o = 1'b1;
                        a_d     = a_i;
                        b_d     = b_i;
                        sign_d  = is_signed_op;
                        cnt_d   = '0;
                        if (is_mul) begin
                            state_d = S_MUL;
                        end else if (b_i == 32'd0) begin
                            // Divide by zero skips the divider.
                            state_d = S_DONE;
                            res_d   = {a_i, 32'hFFFF_FFFF};
                        end else begin
                            state_d = S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    stall_o = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        res_d   = product;
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_DIV: begin
                    stall_o = 1'b1;
                    if (div_ready_i) begin
                        res_d   = div_result_i;
                        state_d = S_DONE;
                    end else begin
                        div_start_o = 1'b1;
                    end
                end
                S_DONE: begin
                    // A request seen here is the retiring instruction.
                    hilo_we_o = 1'b1;
                    state_d   = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign busy_o       = (state_q != S_IDLE);
    assign div_signed_o = sign_q;
    assign div_a_o      = a_q;
    assign div_b_o      = b_q;
    assign hilo_o       = res_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed vectors for muldiv_ctrl, scoreboard on hilo writes.
// Ports: drives every muldiv_ctrl input, observes every output.
module tb_muldiv_ctrl;

    localparam int LAT = 2;
    localparam logic [7:0] OP_MULT  = 8'b0001_1000;
    localparam logic [7:0] OP_MULTU = 8'b0001_1001;
    localparam logic [7:0] OP_DIV   = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
    localparam logic [7:0] OP_ADD   = 8'b0010_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic [7:0]  alucontrol_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        div_ready_i;
    logic [63:0] div_result_i;
    logic        div_start_o;
    logic        div_annul_o;
    logic        div_signed_o;
    logic [31:0] div_a_o;
    logic [31:0] div_b_o;
    logic        stall_o;
    logic        busy_o;
    logic        hilo_we_o;
    logic [63:0] hilo_o;

    typedef struct {
        logic [63:0] val;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    muldiv_ctrl #(.MUL_LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .alucontrol_i (alucontrol_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .flush_i      (flush_i),
        .div_ready_i  (div_ready_i),
        .div_result_i (div_result_i),
        .div_start_o  (div_start_o),
        .div_annul_o  (div_annul_o),
        .div_signed_o (div_signed_o),
        .div_a_o      (div_a_o),
        .div_b_o      (div_b_o),
        .stall_o      (stall_o),
        .busy_o       (busy_o),
        .hilo_we_o    (hilo_we_o),
        .hilo_o       (hilo_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every hilo write must match the oldest expectation,
    // both in value and in the cycle it appears.
    always @(negedge clk) begin
        if (hilo_we_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_hilo_we actual=%h expected=none (cycle %0d)",
                         hilo_o, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk64("hilo_value", hilo_o, e.val);
                chk64("hilo_we_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic run_mul(input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] res);
        int c0;
        step();
        req_valid_i  = 1'b1;
        alucontrol_i = op;
        a_i          = a;
        b_i          = b;
        c0           = cyc;
        exp_q.push_back('{res, c0 + LAT + 1});
        // Request held through DONE: the DONE-cycle request must be ignored.
        for (int k = 0; k <= LAT + 1; k++) begin
            if (k > 0) step();
            @(negedge clk);
            chk1("mul_stall", stall_o, (k <= LAT));
        end
        step();
        req_valid_i = 1'b0;
        @(negedge clk);
        chk1("mul_idle_after", busy_o, 1'b0);
    endtask

    task automatic run_div(input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] res);
        int c0;
        int cr;
        int n;
        int g;
        step();
        req_valid_i  = 1'b1;
        alucontrol_i = op;
        a_i          = a;
        b_i          = b;
        c0           = cyc;
        @(negedge clk);
        chk1("div_req_stall", stall_o, 1'b1);
        chk1("div_req_nostart", div_start_o, 1'b0);
        step();
        req_valid_i = 1'b0;
        n = 0;
        g = 0;
        while (n < 34 && g < 200) begin
            @(negedge clk);
            if (div_start_o) n++;
            g++;
            if (n < 34 && g < 200) step();
        end
        chk64("div_start_count", 64'(n), 64'd34);
        chk64("div_start_contig", 64'(g), 64'd34);
        chk64("div_a_latched", {32'd0, div_a_o}, {32'd0, a});
        chk64("div_b_latched", {32'd0, div_b_o}, {32'd0, b});
        chk1("div_signed", div_signed_o, (op == OP_DIV));
        step();
        div_ready_i  = 1'b1;
        div_result_i = res;
        cr           = cyc;
        chk64("div_ready_cycle", 64'(cr - c0), 64'd35);
        exp_q.push_back('{res, cr + 1});
        @(negedge clk);
        chk1("div_start_dropped", div_start_o, 1'b0);
        chk1("div_ready_stall", stall_o, 1'b1);
        step();
        div_ready_i = 1'b0;
        @(negedge clk);
        chk1("div_done_stall", stall_o, 1'b0);
        step();
        @(negedge clk);
        chk1("div_idle_after", busy_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        req_valid_i  = 1'b0;
        alucontrol_i = '0;
        a_i          = '0;
        b_i          = '0;
        flush_i      = 1'b0;
        div_ready_i  = 1'b0;
        div_result_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk1("rst_stall", stall_o, 1'b0);
        chk1("rst_busy", busy_o, 1'b0);
        chk1("rst_we", hilo_we_o, 1'b0);
        chk64("rst_hilo", hilo_o, 64'd0);
        chk1("rst_start", div_start_o, 1'b0);
        chk1("rst_annul", div_annul_o, 1'b0);
        chk1("rst_signed", div_signed_o, 1'b0);
        chk64("rst_div_a", {32'd0, div_a_o}, 64'd0);

        run_mul(OP_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
        run_mul(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE);
        run_mul(OP_MULT, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE);

        // DIVU by zero: result immediately, divider never started.
        step();
        req_valid_i  = 1'b1;
        alucontrol_i = OP_DIVU;
        a_i          = 32'd9;
        b_i          = 32'd0;
        exp_q.push_back('{64'h0000_0009_FFFF_FFFF, cyc + 1});
        @(negedge clk);
        chk1("dz_stall0", stall_o, 1'b1);
        chk1("dz_start0", div_start_o, 1'b0);
        step();
        req_valid_i = 1'b0;
        @(negedge clk);
        chk1("dz_stall1", stall_o, 1'b0);
        chk1("dz_start1", div_start_o, 1'b0);
        step();
        @(negedge clk);
        chk1("dz_idle", busy_o, 1'b0);

        // -7 / 2 signed: quotient -3, remainder -1.
        run_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);

        // Flush in DIV cycle 10: annul, back to IDLE, no write.
        step();
        req_valid_i  = 1'b1;
        alucontrol_i = OP_DIV;
        a_i          = 32'd100;
        b_i          = 32'd7;
        step();
        req_valid_i = 1'b0;
        for (int k = 1; k < 10; k++) step();
        flush_i = 1'b1;
        @(negedge clk);
        chk1("flush_annul", div_annul_o, 1'b1);
        chk1("flush_start", div_start_o, 1'b0);
        step();
        flush_i = 1'b0;
        @(negedge clk);
        chk1("flush_idle", busy_o, 1'b0);
        chk1("flush_stall", stall_o, 1'b0);
        chk1("flush_annul_off", div_annul_o, 1'b0);
        repeat (3) step();

        run_mul(OP_MULTU, 32'd7, 32'd6, 64'd42);

        // Flush in DONE suppresses the write.
        step();
        req_valid_i  = 1'b1;
        alucontrol_i = OP_MULT;
        a_i          = 32'd3;
        b_i          = 32'd3;
        step();
        req_valid_i = 1'b0;
        repeat (LAT) step();
        flush_i = 1'b1;
        @(negedge clk);
        chk1("flush_done_busy", busy_o, 1'b1);
        chk1("flush_done_we", hilo_we_o, 1'b0);
        step();
        flush_i = 1'b0;
        @(negedge clk);
        chk1("flush_done_idle", busy_o, 1'b0);

        // Flush together with a new request in IDLE: request dropped.
        step();
        req_valid_i  = 1'b1;
        alucontrol_i = OP_MULT;
        flush_i      = 1'b1;
        @(negedge clk);
        chk1("flush_req_stall", stall_o, 1'b0);
        step();
        req_valid_i = 1'b0;
        flush_i     = 1'b0;
        @(negedge clk);
        chk1("flush_req_idle", busy_o, 1'b0);

        // Non-muldiv op is not acted on.
        step();
        req_valid_i  = 1'b1;
        alucontrol_i = OP_ADD;
        a_i          = 32'd1;
        b_i          = 32'd2;
        @(negedge clk);
        chk1("add_stall", stall_o, 1'b0);
        step();
        req_valid_i = 1'b0;
        @(negedge clk);
        chk1("add_idle", busy_o, 1'b0);

        // Reset during MUL cycle 1 clears everything, no write.
        step();
        req_valid_i  = 1'b1;
        alucontrol_i = OP_MULT;
        a_i          = 32'd5;
        b_i          = 32'd6;
        step();
        req_valid_i = 1'b0;
        rst         = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk1("mrst_busy", busy_o, 1'b0);
        chk1("mrst_stall", stall_o, 1'b0);
        chk1("mrst_we", hilo_we_o, 1'b0);
        chk64("mrst_hilo", hilo_o, 64'd0);
        chk1("mrst_start", div_start_o, 1'b0);
        chk64("mrst_div_b", {32'd0, div_b_o}, 64'd0);
        repeat (4) step();

        chk64("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
